bs_rr_arbtr_bp: RTL and testbench
=================================

Name: bs_rr_arbtr_bp

Overview:
- Next-generation single-bus arbiter for the bus-of-data environment.
- Round-robin arbitrates among DRVRS driver-side FIFOs and pops one packet at a time.
- Decodes the destination ID in the packet header, then pushes the packet to one destination, to all drivers (broadcast), or drops it.
- Honours per-destination full backpressure, which the earlier generation lacks. Sits between the per-driver FIFO interface and the driver/monitor agents.

Parameters:
- DRVRS, 4, number of drivers/ports (2..16).
- PCKG_SZ, 16, packet width in bits.
- ID_W, 8, header width; destination ID = D_pop[PCKG_SZ-1 -: ID_W].
- BROADCAST, 8'hFF, ID value meaning "all drivers except the source".

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pndng  in  DRVRS  source FIFO i non-empty; head valid on D_pop slice i.
- D_pop  in  DRVRS*PCKG_SZ  head data of each source FIFO, slice i = [i*PCKG_SZ +: PCKG_SZ].
- pop  out  DRVRS  one-hot single-cycle consume strobe to source FIFO i.
- full  in  DRVRS  destination FIFO i cannot accept.
- push  out  DRVRS  write strobe to destination FIFO(s).
- D_push  out  PCKG_SZ  bus data, common to all destinations.
- busy  out  1  high whenever state != IDLE.
- gnt_id  out  $clog2(DRVRS)  index of the current/last granted source.

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clk): pop=0, push=0, D_push=0, busy=0, gnt_id=0, rr pointer=0, state=IDLE. Reset mid-packet discards the in-flight packet; no further pop/push is issued for it.
- FSM states: IDLE, POP, DECODE, PUSH.
- IDLE: if |pndng, choose the winner W = first set bit searching from rr_ptr upward, modulo DRVRS. Register gnt_id=W and go to POP. Otherwise stay.
- POP (1 cycle): pop[W]=1, latch pkt=D_pop slice W. rr_ptr <= (W+1)%DRVRS. Go to DECODE.
- DECODE (1 cycle): compute target mask.
  - dest<DRVRS: mask = 1<<dest. This includes dest==W (loopback is allowed).
  - dest==BROADCAST: mask = all ones except bit W.
  - Otherwise: mask=0 and the packet is dropped; go to IDLE.
  - Non-zero mask: go to PUSH.
- PUSH: wait while (mask & full) != 0, with push=0 while waiting. When clear, push=mask for exactly 1 cycle, D_push=pkt, then go to IDLE.
- D_push holds the last value outside PUSH.
- Latency: pndng sampled high in IDLE at cycle N gives pop at N+1 and push at N+3 with no backpressure. Minimum spacing is 4 cycles/packet.
- pndng changes during POP..PUSH are ignored until IDLE.
- pndng deasserting in the same cycle as it is sampled in IDLE is a protocol violation by the source; behaviour is not defined.
- No timeout: full held indefinitely stalls the bus with busy=1.
- DRVRS=1 with broadcast gives mask=0, treated as a drop.

Optional Feature:
- Macro BUS_STATS_EN.
- Defined: adds outputs pkt_cnt[31:0] and drop_cnt[15:0].
  - pkt_cnt increments by 1 per completed PUSH cycle; a broadcast counts once.
  - drop_cnt increments per DECODE drop.
  - Both saturate at max value and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package bs_pkg:
  - state_e enum {IDLE,POP,DECODE,PUSH}.
  - Function dest_mask(pkt, src, DRVRS, BROADCAST) returning the target mask.
  - localparam ID_LSB = PCKG_SZ-ID_W.
- Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs one-hot gnt and gnt_idx. Purely combinational; the pointer register stays in the parent.

Test Plan:
- Unicast: DRVRS=4, pndng=4'b0010, D_pop[1]=16'h02AB, full=0 -> pop=4'b0010 at N+1, push=4'b0100 with D_push=16'h02AB at N+3.
- Round-robin fairness: pndng=4'b1111 held, each head ID=0 -> grant order 0,1,2,3,0, one grant every 4 cycles.
- Broadcast: src 2, D_pop=16'hFF5A -> push=4'b1011, D_push=16'hFF5A, single cycle.
- Drop: src 0, D_pop=16'h0711 (ID 7 ≥ 4) -> pop[0] pulses, no push, back to IDLE; drop_cnt=1 with BUS_STATS_EN.
- Backpressure: unicast to 3 with full[3]=1 for 5 cycles -> push=0 during the stall and busy=1; push=4'b1000 on the cycle after full[3] falls.
- Reset mid-operation: assert reset during DECODE -> next cycle all outputs 0 and rr_ptr=0. The same pndng afterwards grants index 0 first, and the lost packet is never pushed.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared types and helpers for the bs_rr_arbtr_bp bus arbiter: FSM state
// encoding, default geometry and the destination-mask decode.
package bs_pkg;

  localparam int PCKG_SZ_DFLT = 16;
  localparam int ID_W_DFLT    = 8;
  localparam int ID_LSB       = PCKG_SZ_DFLT - ID_W_DFLT;

  // Upper bounds for the decode helper; DRVRS is limited to 16, IDs to 32 bits.
  localparam int MAX_DRVRS = 16;
  localparam int MAX_ID_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    DECODE,
    PUSH
  } state_e;

  // Unicast IDs below drvrs select one port (loopback allowed); the broadcast ID
  // selects every port but the source; anything else yields an empty mask (drop).
  function automatic logic [MAX_DRVRS-1:0] dest_mask(
    input logic [MAX_ID_W-1:0] hdr,
    input int                  src,
    input int                  drvrs,
    input logic [MAX_ID_W-1:0] bcast
  );
    logic [MAX_DRVRS-1:0] all_m;
    dest_mask = '0;
    all_m     = '0;
    for (int i = 0; i < MAX_DRVRS; i++) begin
      all_m[i] = (i < drvrs);
    end
    if (hdr < 32'(drvrs)) begin
      dest_mask[hdr[3:0]] = 1'b1;
    end else if (hdr == bcast) begin
      dest_mask = all_m & ~(MAX_DRVRS'(1) << src);
    end
  endfunction

endpackage

// File: rtl/bs_rr_arbtr_bp_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  always_comb begin
    int   idx;
    logic found;
    // NOTE: every variable written here gets a default first so no latch is inferred.
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/bs_rr_arbtr_bp.sv
// Single-bus round-robin arbiter with per-destination full backpressure.
// Optional BUS_STATS_EN adds saturating pkt_cnt/drop_cnt outputs.
module bs_rr_arbtr_bp
  import bs_pkg::*;
#(
  parameter  int               DRVRS     = 4,
  parameter  int               PCKG_SZ   = PCKG_SZ_DFLT,
  parameter  int               ID_W      = ID_W_DFLT,
  parameter  logic [ID_W-1:0]  BROADCAST = 8'hFF,
  localparam int               IDX_W     = $clog2(DRVRS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DRVRS-1:0]         pndng,
  input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
  output logic [DRVRS-1:0]         pop,
  input  logic [DRVRS-1:0]         full,
  output logic [DRVRS-1:0]         push,
  output logic [PCKG_SZ-1:0]       D_push,
  output logic                     busy,
  output logic [IDX_W-1:0]         gnt_id
`ifdef BUS_STATS_EN
  ,
  output logic [31:0]              pkt_cnt,
  output logic [15:0]              drop_cnt
`endif
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [DRVRS-1:0]     pop_q, pop_d;
  logic [PCKG_SZ-1:0]   dpush_q, dpush_d;
  logic [PCKG_SZ-1:0]   pkt_q, pkt_d;
  logic [DRVRS-1:0]     mask_q, mask_d;
  logic [MAX_DRVRS-1:0] mask_full;
  logic [DRVRS-1:0]     arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 blocked;
`ifdef BUS_STATS_EN
  logic [31:0]          pkt_cnt_q, pkt_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
`endif

  rr_arbiter #(.N(DRVRS)) u_arb (
    .req_i     (pndng),
    .ptr_i     (rr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  assign blocked = |(mask_q & full);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    pop_d     = '0;
    dpush_d   = dpush_q;
    pkt_d     = pkt_q;
    mask_d    = mask_q;
    mask_full = '0;
`ifdef BUS_STATS_EN
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|pndng) begin
          state_d = POP;
          gnt_d   = arb_idx;
          pop_d   = arb_gnt;
        end
      end
      POP: begin
        pkt_d   = D_pop[int'(gnt_q)*PCKG_SZ +: PCKG_SZ];
        rr_d    = (int'(gnt_q) == DRVRS-1) ? '0 : gnt_q + 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        mask_full = dest_mask(MAX_ID_W'(pkt_q[PCKG_SZ-1 -: ID_W]), int'(gnt_q), DRVRS,
                              MAX_ID_W'(BROADCAST));
        mask_d    = mask_full[DRVRS-1:0];
        if (mask_full == '0) begin
          state_d = IDLE;
`ifdef BUS_STATS_EN
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
`endif
        end else begin
          state_d = PUSH;
          dpush_d = pkt_q;
        end
      end
      PUSH: begin
        if (!blocked) begin
          state_d = IDLE;
`ifdef BUS_STATS_EN
          if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      pop_q   <= '0;
      dpush_q <= '0;
`ifdef BUS_STATS_EN
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      pop_q   <= pop_d;
      dpush_q <= dpush_d;
`ifdef BUS_STATS_EN
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  // NOTE: packet and mask are only read after being loaded, so they carry no reset.
  always_ff @(posedge clk) begin
    pkt_q  <= pkt_d;
    mask_q <= mask_d;
  end

  // Push follows full combinationally so a release is used in the same cycle.
  assign push   = (state_q == PUSH && !blocked) ? mask_q : '0;
  assign pop    = pop_q;
  assign D_push = dpush_q;
  assign busy   = (state_q != IDLE);
  assign gnt_id = gnt_q;
`ifdef BUS_STATS_EN
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bs_rr_arbtr_bp.sv
// Directed bench for bs_rr_arbtr_bp with a push scoreboard; build with
// BUS_STATS_EN defined to also check the statistics counters.
module tb_bs_rr_arbtr_bp;

  localparam int DRVRS   = 4;
  localparam int PCKG_SZ = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [DRVRS-1:0]         pndng;
  logic [DRVRS*PCKG_SZ-1:0] d_pop;
  logic [DRVRS-1:0]         pop;
  logic [DRVRS-1:0]         full;
  logic [DRVRS-1:0]         push;
  logic [PCKG_SZ-1:0]       d_push;
  logic                     busy;
  logic [1:0]               gnt_id;
`ifdef BUS_STATS_EN
  logic [31:0]              pkt_cnt;
  logic [15:0]              drop_cnt;
`endif

  typedef struct {
    logic [DRVRS-1:0]   mask;
    logic [PCKG_SZ-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;

  bs_rr_arbtr_bp #(.DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ), .ID_W(8), .BROADCAST(8'hFF)) dut (
    .clk    (clk),
    .reset  (reset),
    .pndng  (pndng),
    .D_pop  (d_pop),
    .pop    (pop),
    .full   (full),
    .push   (push),
    .D_push (d_push),
    .busy   (busy),
    .gnt_id (gnt_id)
`ifdef BUS_STATS_EN
    ,
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every push seen on the bus must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (push !== '0) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_push: observed push %b expected none", push);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_mask", 32'(push), 32'(e.mask));
        check("sb_data", 32'(d_push), 32'(e.data));
      end
    end
  end

  initial begin
    reset = 1'b1;
    pndng = '0;
    d_pop = '0;
    full  = '0;
    tick();
    tick();
    check("rst_pop", 32'(pop), 0);
    check("rst_push", 32'(push), 0);
    check("rst_dpush", 32'(d_push), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt", 32'(gnt_id), 0);

    // Unicast 1 -> 2
    reset = 1'b0;
    tick();
    d_pop[1*PCKG_SZ +: PCKG_SZ] = 16'h02AB;
    pndng = 4'b0010;
    sb.push_back('{4'b0100, 16'h02AB});
    tick();
    check("uni_pop", 32'(pop), 32'h2);
    check("uni_gnt", 32'(gnt_id), 1);
    check("uni_busy", 32'(busy), 1);
    pndng = '0;
    tick();
    check("uni_pop_off", 32'(pop), 0);
    check("uni_no_early_push", 32'(push), 0);
    tick();
    check("uni_push", 32'(push), 32'h4);
    check("uni_dpush", 32'(d_push), 32'h02AB);
    tick();
    check("uni_push_off", 32'(push), 0);
    check("uni_idle", 32'(busy), 0);
    check("uni_dpush_hold", 32'(d_push), 32'h02AB);

    // Round-robin fairness from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < DRVRS; i++) d_pop[i*PCKG_SZ +: PCKG_SZ] = 16'h00A0 + 16'(i);
    pndng = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int w;
      w = k % DRVRS;
      sb.push_back('{4'b0001, 16'h00A0 + 16'(w)});
      tick();
      check("rr_pop", 32'(pop), 32'(1 << w));
      check("rr_gnt", 32'(gnt_id), 32'(w));
      if (k == 4) pndng = '0;
      tick();
      tick();
      check("rr_push", 32'(push), 32'h1);
      tick();
      check("rr_idle", 32'(busy), 0);
    end

    // Broadcast from source 2
    d_pop[2*PCKG_SZ +: PCKG_SZ] = 16'hFF5A;
    pndng = 4'b0100;
    sb.push_back('{4'b1011, 16'hFF5A});
    tick();
    check("bc_pop", 32'(pop), 32'h4);
    pndng = '0;
    tick();
    tick();
    check("bc_push", 32'(push), 32'hB);
    check("bc_dpush", 32'(d_push), 32'hFF5A);
    tick();
    check("bc_single", 32'(push), 0);

    // Drop: ID 7 is neither a port nor broadcast
    d_pop[0 +: PCKG_SZ] = 16'h0711;
    pndng = 4'b0001;
    tick();
    check("drop_pop", 32'(pop), 32'h1);
    check("drop_gnt", 32'(gnt_id), 0);
    pndng = '0;
    tick();
    tick();
    check("drop_idle", 32'(busy), 0);
    check("drop_push", 32'(push), 0);
`ifdef BUS_STATS_EN
    check("drop_cnt", 32'(drop_cnt), 1);
    check("pkt_cnt", pkt_cnt, 6);
`endif

    // Loopback 3 -> 3 while every other destination is full
    d_pop[3*PCKG_SZ +: PCKG_SZ] = 16'h0399;
    full  = 4'b0111;
    pndng = 4'b1000;
    sb.push_back('{4'b1000, 16'h0399});
    tick();
    check("lb_pop", 32'(pop), 32'h8);
    pndng = '0;
    tick();
    tick();
    check("lb_push", 32'(push), 32'h8);
    tick();
    full = '0;

    // Backpressure: 1 -> 3 with full[3] held for 5 cycles
    d_pop[1*PCKG_SZ +: PCKG_SZ] = 16'h03C3;
    full  = 4'b1000;
    pndng = 4'b0010;
    sb.push_back('{4'b1000, 16'h03C3});
    tick();
    check("bp_pop", 32'(pop), 32'h2);
    pndng = '0;
    tick();
    for (int s = 0; s < 5; s++) begin
      tick();
      check("bp_stall_push", 32'(push), 0);
      check("bp_stall_busy", 32'(busy), 1);
    end
    full = '0;
    #1;
    check("bp_release_push", 32'(push), 32'h8);
    check("bp_release_data", 32'(d_push), 32'h03C3);
    tick();
    check("bp_done_push", 32'(push), 0);
    check("bp_done_idle", 32'(busy), 0);

    // Reset during DECODE; pointer is 2 so source 2 wins first
    d_pop[0 +: PCKG_SZ]         = 16'h0266;
    d_pop[2*PCKG_SZ +: PCKG_SZ] = 16'h0155;
    d_pop[3*PCKG_SZ +: PCKG_SZ] = 16'h0377;
    pndng = 4'b1101;
    tick();
    check("mr_pop", 32'(pop), 32'h4);
    check("mr_gnt", 32'(gnt_id), 2);
    tick();
    reset = 1'b1;
    tick();
    check("mr_rst_pop", 32'(pop), 0);
    check("mr_rst_push", 32'(push), 0);
    check("mr_rst_dpush", 32'(d_push), 0);
    check("mr_rst_busy", 32'(busy), 0);
    check("mr_rst_gnt", 32'(gnt_id), 0);
`ifdef BUS_STATS_EN
    check("mr_rst_pkt_cnt", pkt_cnt, 0);
    check("mr_rst_drop_cnt", 32'(drop_cnt), 0);
`endif
    reset = 1'b0;
    sb.push_back('{4'b0100, 16'h0266});
    tick();
    check("mr_after_pop", 32'(pop), 32'h1);
    check("mr_after_gnt", 32'(gnt_id), 0);
    pndng = '0;
    tick();
    tick();
    check("mr_after_push", 32'(push), 32'h4);
    check("mr_after_dpush", 32'(d_push), 32'h0266);
    tick();
    tick();
    tick();
    check("mr_final_idle", 32'(busy), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
